// File: rtl/led_mode_if.sv
// Mode scheduler bus: button/auto/mask controls in, selected mode and change strobe out.
interface led_mode_if;
  logic       btn_next;
  logic       auto_en;
  logic [3:0] mode_mask;
  logic [1:0] mode;
  logic       mode_strobe;

  modport master (
    output btn_next,
    output auto_en,
    output mode_mask,
    input  mode,
    input  mode_strobe
  );

  modport slave (
    input  btn_next,
    input  auto_en,
    input  mode_mask,
    output mode,
    output mode_strobe
  );
endinterface

// File: rtl/led_mode_scheduler.sv
// LED pattern mode scheduler: debounced button advance, timed auto-advance,
// and mask-driven skipping/forcing of disabled modes.
module led_mode_scheduler #(
  parameter int unsigned DWELL_CYCLES    = 10000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  led_mode_if.slave   bus
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int unsigned DwW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DwW-1:0] DwLast = DwW'(DWELL_CYCLES - 1);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StArming    = 2'd1;
  localparam logic [1:0] StPressed   = 2'd2;
  localparam logic [1:0] StReleasing = 2'd3;

  // Button synchronizer
  logic sync1_q, btn_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync1_q <= bus.btn_next;
      btn_s   <= sync1_q;
    end
  end

  // Debounce FSM
  logic [1:0]     st_q, st_d;
  logic [DbW-1:0] cnt_q, cnt_d;
  logic           press_q, press_d;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (st_q)
      StIdle: begin
        if (btn_s) begin
          if (DEBOUNCE_CYCLES <= 1) begin
            st_d    = StPressed;
            press_d = 1'b1;
            cnt_d   = '0;
          end else begin
            st_d  = StArming;
            cnt_d = DbW'(1);
          end
        end
      end
      StArming: begin
        if (!btn_s) begin
          st_d  = StIdle;
          cnt_d = '0;
        end else if (cnt_q >= DbLast) begin
          // The sample that brings the count to DEBOUNCE_CYCLES accepts the press
          st_d    = StPressed;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DbW'(1);
        end
      end
      StPressed: begin
        if (!btn_s) begin
          if (DEBOUNCE_CYCLES <= 1) begin
            st_d  = StIdle;
            cnt_d = '0;
          end else begin
            st_d  = StReleasing;
            cnt_d = DbW'(1);
          end
        end
      end
      StReleasing: begin
        if (btn_s) begin
          // Bounce during release: back to held, no new request
          st_d  = StPressed;
          cnt_d = '0;
        end else if (cnt_q >= DbLast) begin
          st_d  = StIdle;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + DbW'(1);
        end
      end
      default: begin
        st_d  = StIdle;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= StIdle;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Next enabled mode search and advance decision
  logic [1:0] mode_q, next_mode, cand;
  logic       found, forced, auto_req, advance, strobe_q;
  logic [DwW-1:0] dwell_q, dwell_d;

  always_comb begin
    found     = 1'b0;
    next_mode = mode_q;
    cand      = mode_q;
    // Descending scan so the smallest offset wins
    for (int k = 3; k >= 1; k--) begin
      cand = mode_q + 2'(k);
      if (bus.mode_mask[cand]) begin
        found     = 1'b1;
        next_mode = cand;
      end
    end
  end

  assign auto_req = bus.auto_en && (dwell_q >= DwLast);
  assign forced   = !bus.mode_mask[mode_q] && (bus.mode_mask != 4'b0000);
  assign advance  = found && (press_q || auto_req || forced);

  always_comb begin
    if (advance || !bus.auto_en || auto_req) begin
      dwell_d = '0;
    end else begin
      dwell_d = dwell_q + DwW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= 2'b00;
      strobe_q <= 1'b0;
      dwell_q  <= '0;
    end else begin
      strobe_q <= advance;
      dwell_q  <= dwell_d;
      if (advance) begin
        mode_q <= next_mode;
      end
    end
  end

  assign bus.mode        = mode_q;
  assign bus.mode_strobe = strobe_q;

endmodule

// File: doc/led_mode_scheduler.md
LED_MODE_SCHEDULER -- requirements
Module: led_mode_scheduler

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 10000, meaning clock cycles each mode is held during auto-advance.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable synchronized samples needed to accept a button press or release.
REQ-003 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port btn_next  input  1  raw asynchronous push-button, active-high; a press requests the next mode.
REQ-006 SHALL have port auto_en  input  1  when 1, the mode advances automatically every DWELL_CYCLES.
REQ-007 SHALL have port mode_mask  input  4  bit i = 1 means mode i is enabled.
REQ-008 SHALL have port mode  output  2  selected pattern; drives the pattern generator's mode input.
REQ-009 SHALL have port mode_strobe  output  1  one-cycle pulse in the first cycle a new mode value is visible.
REQ-010 SHALL use one clock domain (clk) and one asynchronous active-high reset (rst).

Function
REQ-011 SHALL pass btn_next through a 2-flop synchronizer; only the synchronized signal (btn_s) feeds the debounce FSM.
REQ-012 SHALL implement the debounce FSM states: IDLE, ARMING, PRESSED, RELEASING.
REQ-013 IDLE SHALL go to ARMING when btn_s=1; the count starts at 1.
REQ-014 ARMING SHALL increment the count while btn_s=1, go to PRESSED when the count reaches DEBOUNCE_CYCLES, and go back to IDLE with the count cleared if btn_s=0.
REQ-015 Entry into PRESSED SHALL raise exactly one manual advance request for one cycle; the FSM stays in PRESSED while btn_s=1.
REQ-016 PRESSED SHALL go to RELEASING when btn_s=0.
REQ-017 RELEASING SHALL count consecutive btn_s=0 samples, return to IDLE after DEBOUNCE_CYCLES, and return to PRESSED with no new request if btn_s=1.
REQ-018 Dwell counter behaviour:
- with auto_en=1, counts 0..DWELL_CYCLES-1;
- at the terminal count, raises one auto advance request and reloads 0;
- with auto_en=0, is held at 0.
REQ-019 Any mode change (manual, auto or forced) SHALL clear the dwell counter to 0.
REQ-020 Next mode SHALL be (mode+k) mod 4 for the smallest k in 1..3 with mode_mask set; if no such k exists, mode is unchanged and there is no strobe. Wrap is 3 -> 0.
REQ-021 A manual and an auto request in the same cycle SHALL produce exactly one advance.
REQ-022 If mode_mask[mode]=0 and any other mask bit is set, mode SHALL be force-advanced per REQ-020 at the next edge, with a strobe.
REQ-023 If mode_mask=0000, mode SHALL hold its value, with no strobes.
REQ-024 A request SHALL update mode at the next rising edge; mode_strobe SHALL be high in that same cycle only.
REQ-025 With btn_next held high and no bounce, mode SHALL update at the (DEBOUNCE_CYCLES+3)th rising edge after the first edge that samples btn_next high.
REQ-026 mode SHALL be registered and glitch-free; a change of mode_mask alone SHALL never produce a strobe unless it forces a change (REQ-022).

Reset
REQ-027 While rst=1, outputs SHALL be mode=00 and mode_strobe=0; sync flops, counters and dwell counter SHALL be 0, and the FSM SHALL be in IDLE, all immediately without waiting for a clock edge.
REQ-028 After rst deasserts, a button still held SHALL be debounced anew, giving one advance after REQ-025 latency.
REQ-029 Reset asserted mid-debounce or mid-dwell SHALL discard the partial count; no pending request survives reset.
REQ-030 If mode_mask[0]=0 at reset release, REQ-022 SHALL apply at the first edge after release.

Verification
REQ-031 Reset release with mask=1111, auto_en=1, DWELL_CYCLES=10 -> mode goes 0,1,2,3,0 with changes every 10 cycles, one strobe per change.
REQ-032 mask=1010, auto_en=1 -> mode goes 0 (forced, first edge) ->1 ->3 ->1; modes 0 and 2 are never re-entered.
REQ-033 auto_en=0, DEBOUNCE_CYCLES=16; btn_next bounces 5 times with pulses shorter than 16 cycles, then is held 40 cycles -> exactly one advance, at REQ-025 latency from the start of the stable hold; no advance on release.
REQ-034 Button request coinciding with a dwell terminal count -> mode advances by exactly one step and the dwell counter restarts at 0.
REQ-035 mask=0000 with auto_en=1 and repeated button presses -> mode stays unchanged and mode_strobe stays 0.
REQ-036 rst asserted for 1 cycle mid-ARMING with mode=2 -> mode=0 immediately; a still-held button yields a single advance to 1 at REQ-025 latency after release.
